// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle memory port between the fetch
// stage (instruction reads) and the memory stage (data reads/writes).
// Data wins arbitration by default (it belongs to the older instruction);
// after MAX_I_WAIT consecutive lost arbitrations, fetch is granted instead.
// Optional macro ARB_PERF_CNT_EN adds conflict/starvation counter outputs.
module mem_port_arbiter #(
  parameter int unsigned MAX_I_WAIT = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  // fetch requester
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  // data requester
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_access_size,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  // memory port
  output logic              mem_enable,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_access_size,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_done
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       starve_grant_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_I,
    S_ISSUE_D,
    S_WAIT_I,
    S_WAIT_D,
    S_DONE_I,
    S_DONE_D
  } state_t;

  localparam logic [7:0] LP_MAX_I_WAIT = 8'(MAX_I_WAIT);

  state_t            r_state;
  logic [7:0]        r_i_wait_cnt;
  logic              r_mem_enable;
  logic              r_mem_rw;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [1:0]        r_mem_size;
  logic              r_i_ready;
  logic              r_d_ready;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_both;
  logic w_starve;
  logic w_grant_i;
  logic w_grant_d;

  // Fetch is forced through once it has lost MAX_I_WAIT arbitrations in a row.
  assign w_both    = i_req & d_req;
  assign w_starve  = (r_i_wait_cnt >= LP_MAX_I_WAIT);
  assign w_grant_i = i_req & (~d_req | w_starve);
  assign w_grant_d = d_req & ~w_grant_i;

  // Arbitration, issue/wait handshake and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_i_wait_cnt <= '0;
      r_mem_enable <= 1'b0;
      r_mem_rw     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_size   <= '0;
      r_i_ready    <= 1'b0;
      r_d_ready    <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_mem_enable <= 1'b0;
      r_i_ready    <= 1'b0;
      r_d_ready    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_i) begin
            r_state      <= S_ISSUE_I;
            r_mem_enable <= 1'b1;
            r_mem_rw     <= 1'b1;
            r_mem_addr   <= i_addr;
            r_mem_wdata  <= '0;
            r_mem_size   <= 2'b00;
            r_i_wait_cnt <= '0;
          end else if (w_grant_d) begin
            r_state      <= S_ISSUE_D;
            r_mem_enable <= 1'b1;
            r_mem_rw     <= d_rw;
            r_mem_addr   <= d_addr;
            r_mem_wdata  <= d_wdata;
            r_mem_size   <= d_access_size;
            if (w_both && (r_i_wait_cnt != 8'hFF)) begin
              r_i_wait_cnt <= r_i_wait_cnt + 8'd1;
            end
          end
        end
        S_ISSUE_I: r_state <= S_WAIT_I;
        S_ISSUE_D: r_state <= S_WAIT_D;
        S_WAIT_I: begin
          if (mem_done) begin
            r_i_rdata <= mem_data_out;
            r_i_ready <= 1'b1;
            r_state   <= S_DONE_I;
          end
        end
        S_WAIT_D: begin
          if (mem_done) begin
            if (r_mem_rw) begin
              r_d_rdata <= mem_data_out;
            end
            r_d_ready <= 1'b1;
            r_state   <= S_DONE_D;
          end
        end
        S_DONE_I: r_state <= S_IDLE;
        S_DONE_D: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_enable      = r_mem_enable;
  assign mem_rw          = r_mem_rw;
  assign mem_address     = r_mem_addr;
  assign mem_data_in     = r_mem_wdata;
  assign mem_access_size = r_mem_size;
  assign i_ready         = r_i_ready;
  assign d_ready         = r_d_ready;
  assign i_rdata         = r_i_rdata;
  assign d_rdata         = r_d_rdata;

  // Stalls are gated by reset so every output reads 0 while reset is held.
  assign i_stall = reset_n & i_req & ~r_i_ready;
  assign d_stall = reset_n & d_req & ~r_d_ready;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_conflict_cnt;
  logic [31:0] r_starve_grant_cnt;

  // Count contested arbitrations and forced fetch grants; both wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_conflict_cnt     <= '0;
      r_starve_grant_cnt <= '0;
    end else if (r_state == S_IDLE && w_both) begin
      r_conflict_cnt <= r_conflict_cnt + 32'd1;
      if (w_starve) begin
        r_starve_grant_cnt <= r_starve_grant_cnt + 32'd1;
      end
    end
  end

  assign conflict_cnt     = r_conflict_cnt;
  assign starve_grant_cnt = r_starve_grant_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected memory
// issues and responses into queues; a monitor pops and compares whenever the
// DUT issues to memory or pulses a ready. A behavioural memory answers issues.
module tb_mem_port_arbiter;

  localparam int unsigned MAXW = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        i_stall;
  logic        d_req;
  logic        d_rw;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_access_size;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_enable;
  logic        mem_rw;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic [31:0] mem_data_out;
  logic        mem_done;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt;
  logic [31:0] starve_grant_cnt;
`endif

  always #5 clock = ~clock;

  mem_port_arbiter #(.MAX_I_WAIT(MAXW), .ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_access_size(d_access_size), .d_ready(d_ready), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_access_size(mem_access_size),
    .mem_data_out(mem_data_out), .mem_done(mem_done)
`ifdef ARB_PERF_CNT_EN
    , .conflict_cnt(conflict_cnt), .starve_grant_cnt(starve_grant_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] wdata;
    logic [1:0]  size;
  } iss_t;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
  } dexp_t;

  iss_t        i_iss_q[$];
  iss_t        d_iss_q[$];
  logic [31:0] i_exp_q[$];
  dexp_t       d_exp_q[$];
  bit          grant_q[$];   // 1 = fetch, 0 = data

  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] emu_mem[logic [31:0]];
  int          mem_delay;
  bit          rand_delay;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h8002_0000) return 32'h8FA2_0004;
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s at %0t", name, what, $time);
  endtask

  // Behavioural memory: answers each issue after a delay of 1..N cycles.
  logic [31:0] e_addr, e_wd;
  logic        e_rw;
  int          e_dly;
  initial begin
    mem_done     = 1'b0;
    mem_data_out = '0;
    forever begin
      @(negedge clock);
      if (reset_n && mem_enable) begin
        e_addr = mem_address;
        e_rw   = mem_rw;
        e_wd   = mem_data_in;
        e_dly  = rand_delay ? int'($urandom_range(1, 4)) : mem_delay;
        repeat (e_dly) @(posedge clock);
        #1;
        if (!e_rw) begin
          emu_mem[e_addr] = e_wd;
          mem_data_out    = $urandom;
        end else begin
          mem_data_out = emu_mem.exists(e_addr) ? emu_mem[e_addr] : imem_word(e_addr);
        end
        mem_done = 1'b1;
        @(posedge clock);
        #1 mem_done = 1'b0;
      end
    end
  end

  // Monitor: checks issues, address stability, ready data and held data.
  bit          m_busy = 0;
  bit          m_prev_en = 0;
  bit          m_side;
  logic [31:0] m_cur_addr;
  logic [31:0] m_last_i = '0;
  logic [31:0] m_last_d = '0;
  iss_t        m_e;
  logic [31:0] m_ie;
  dexp_t       m_de;
  bit          m_g;
  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        m_busy = 0; m_prev_en = 0; m_last_i = '0; m_last_d = '0;
      end else begin
        if (mem_enable) begin
          chk("enable_single_cycle", 32'(m_prev_en), 32'd0);
          if (i_iss_q.size() > 0 && mem_address === i_iss_q[0].addr &&
              mem_rw === 1'b1 && mem_access_size === 2'b00) begin
            m_e = i_iss_q.pop_front();
            m_side = 1'b1;
            m_cur_addr = m_e.addr;
          end else if (d_iss_q.size() > 0) begin
            m_e = d_iss_q.pop_front();
            m_side = 1'b0;
            m_cur_addr = m_e.addr;
            chk("d_issue_addr", mem_address, m_e.addr);
            chk("d_issue_rw", 32'(mem_rw), 32'(m_e.rw));
            chk("d_issue_wdata", mem_data_in, m_e.wdata);
            chk("d_issue_size", 32'(mem_access_size), 32'(m_e.size));
          end else begin
            fail_event("unexpected_issue", $sformatf("addr 0x%08h with nothing pending", mem_address));
            m_side = 1'b0;
            m_cur_addr = mem_address;
          end
          if (grant_q.size() > 0) begin
            m_g = grant_q.pop_front();
            chk("grant_order_is_fetch", 32'(m_side), 32'(m_g));
          end
          m_busy = 1;
        end else if (m_busy) begin
          chk("addr_stable", mem_address, m_cur_addr);
        end
        m_prev_en = mem_enable;

        if (i_ready) begin
          if (i_exp_q.size() == 0) fail_event("i_ready_unexpected", "pulse with no fetch outstanding");
          else begin
            m_ie = i_exp_q.pop_front();
            chk("i_rdata", i_rdata, m_ie);
            m_last_i = m_ie;
          end
          m_busy = 0;
        end else begin
          chk("i_rdata_hold", i_rdata, m_last_i);
        end

        if (d_ready) begin
          if (d_exp_q.size() == 0) fail_event("d_ready_unexpected", "pulse with no data access outstanding");
          else begin
            m_de = d_exp_q.pop_front();
            if (m_de.is_read) m_last_d = m_de.data;
            chk("d_rdata", d_rdata, m_last_d);
          end
          m_busy = 0;
        end else begin
          chk("d_rdata_hold", d_rdata, m_last_d);
        end
      end
    end
  end

  // Fetch transaction; exp_lat > 0 also checks stall and latency cycle by cycle.
  task automatic i_txn(input logic [31:0] a, input int exp_lat, output int lat);
    @(posedge clock); #1;
    i_req  = 1'b1;
    i_addr = a;
    i_iss_q.push_back('{a, 1'b1, 32'h0, 2'b00});
    i_exp_q.push_back(imem_word(a));
    lat = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (exp_lat > 0 && c <= exp_lat) chk("i_stall", 32'(i_stall), 32'(c != exp_lat));
      if (i_ready) begin lat = c; break; end
    end
    if (lat < 0) fail_event("i_timeout", $sformatf("no i_ready for 0x%08h", a));
    else if (exp_lat > 0) chk("i_latency", lat, exp_lat);
  endtask

  // Data transaction; also counts mem_enable pulses while it is outstanding.
  task automatic d_txn(input logic [31:0] a, input logic rw, input logic [31:0] wd,
                       input logic [1:0] sz, input int exp_lat, output int lat, output int n_en);
    logic [31:0] exp_rd;
    @(posedge clock); #1;
    d_req = 1'b1; d_rw = rw; d_addr = a; d_wdata = wd; d_access_size = sz;
    d_iss_q.push_back('{a, rw, wd, sz});
    exp_rd = ref_mem.exists(a) ? ref_mem[a] : imem_word(a);
    d_exp_q.push_back('{rw, rw ? exp_rd : 32'h0});
    if (!rw) ref_mem[a] = wd;
    lat = -1;
    n_en = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (mem_enable) n_en++;
      if (exp_lat > 0 && c <= exp_lat) chk("d_stall", 32'(d_stall), 32'(c != exp_lat));
      if (d_ready) begin lat = c; break; end
    end
    if (lat < 0) fail_event("d_timeout", $sformatf("no d_ready for 0x%08h", a));
    else if (exp_lat > 0) chk("d_latency", lat, exp_lat);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_i_ready"}, 32'(i_ready), 32'd0);
    chk({tag, "_i_rdata"}, i_rdata, 32'd0);
    chk({tag, "_i_stall"}, 32'(i_stall), 32'd0);
    chk({tag, "_d_ready"}, 32'(d_ready), 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_d_stall"}, 32'(d_stall), 32'd0);
    chk({tag, "_mem_enable"}, 32'(mem_enable), 32'd0);
    chk({tag, "_mem_rw"}, 32'(mem_rw), 32'd0);
    chk({tag, "_mem_address"}, mem_address, 32'd0);
    chk({tag, "_mem_data_in"}, mem_data_in, 32'd0);
    chk({tag, "_mem_access_size"}, 32'(mem_access_size), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int lat, n_en, cnt;
  initial begin
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_rw = 1'b0; d_addr = '0; d_wdata = '0; d_access_size = '0;
    mem_delay = 1; rand_delay = 0;
    repeat (3) @(posedge clock);
    #1 chk_all_zero("reset");
    i_req = 1'b1;
    d_req = 1'b1;
    #1 chk_all_zero("reset_req_high");
    i_req = 1'b0;
    d_req = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;

    // Single fetch, memory answers in the first wait cycle.
    i_txn(32'h8002_0000, 3, lat);
    @(posedge clock); #1 i_req = 1'b0;

    // Single byte store.
    d_txn(32'h8002_0010, 1'b0, 32'hDEAD_BEEF, 2'b00, 3, lat, n_en);
    chk("d_write_enable_pulses", n_en, 1);
    @(posedge clock); #1 d_req = 1'b0;

    // Both held continuously: grant sequence from the fetch-wait counter rule.
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (cnt < int'(MAXW)) begin grant_q.push_back(1'b0); cnt++; end
      else begin grant_q.push_back(1'b1); cnt = 0; end
    end
    grant_q.push_back(1'b0);
    fork
      begin
        int l1;
        for (int k = 0; k < 2; k++) i_txn(32'h8003_0000 + 32'(4 * k), 0, l1);
        @(posedge clock); #1 i_req = 1'b0;
      end
      begin
        int l2, e2;
        for (int k = 0; k < 9; k++)
          d_txn(32'h1000_0000 + 32'(4 * (k % 4)), 1'(k % 2), $urandom, 2'b10, 0, l2, e2);
        @(posedge clock); #1 d_req = 1'b0;
      end
    join
    chk("grant_q_drained", grant_q.size(), 0);
`ifdef ARB_PERF_CNT_EN
    chk("conflict_cnt", conflict_cnt, 32'd10);
    chk("starve_grant_cnt", starve_grant_cnt, 32'd2);
`endif

    // Slow data read: done five cycles after the issue.
    ref_mem[32'h1000_0100] = 32'h1234_5678;
    emu_mem[32'h1000_0100] = 32'h1234_5678;
    mem_delay = 5;
    d_txn(32'h1000_0100, 1'b1, 32'h0BAD_F00D, 2'b10, 7, lat, n_en);
    chk("d_slow_enable_pulses", n_en, 1);
    @(posedge clock); #1 d_req = 1'b0;

    // Reset while waiting on memory; the late completion must be ignored.
    mem_delay = 10;
    @(posedge clock); #1;
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h1000_0104; d_wdata = 32'h0; d_access_size = 2'b10;
    d_iss_q.push_back('{32'h1000_0104, 1'b1, 32'h0, 2'b10});
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (mem_enable) begin lat = c; break; end
    end
    if (lat < 0) fail_event("rst_issue_timeout", "no mem_enable before reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1 chk_all_zero("mid_wait_reset");
    d_req = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (15) @(posedge clock);
    mem_delay = 1;
    i_txn(32'h8005_0000, 3, lat);
    @(posedge clock); #1 i_req = 1'b0;

    // Randomized mix with random memory latency.
    rand_delay = 1;
    fork
      begin
        int l3;
        for (int k = 0; k < 25; k++) begin
          i_txn(32'h8004_0000 + 32'(4 * k), 0, l3);
          if ($urandom_range(0, 1) == 1) begin
            @(posedge clock); #1 i_req = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clock);
          end
        end
        @(posedge clock); #1 i_req = 1'b0;
      end
      begin
        int l4, e4;
        for (int k = 0; k < 25; k++) begin
          d_txn(32'h1000_0000 + 32'(4 * $urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                $urandom, 2'($urandom_range(0, 3)), 0, l4, e4);
          if ($urandom_range(0, 1) == 1) begin
            @(posedge clock); #1 d_req = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clock);
          end
        end
        @(posedge clock); #1 d_req = 1'b0;
      end
    join
    repeat (10) @(posedge clock);
    chk("i_exp_q_drained", i_exp_q.size(), 0);
    chk("d_exp_q_drained", d_exp_q.size(), 0);
    chk("i_iss_q_drained", i_iss_q.size(), 0);
    chk("d_iss_q_drained", d_iss_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
